pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter stage for each core's fetch path.
- Holds the current PC and drives it, with the increment constant, into the 32-bit adder.
- Takes the adder's sum back as the sequential next PC and arbitrates it against branch redirects, exception entry and stalls.
- Presents fetch requests to instruction memory with a valid/ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- INC, 32'd4, sequential increment driven on AddB.
- EXC_VECTOR, 32'h0000_0080, PC loaded on exception entry.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-low reset.
- AddA  output  32  current PC, wired to the adder's A input.
- AddB  output  32  constant INC, wired to the adder's B input.
- AddSum  input  32  adder result; the adder is combinational, so this is AddA+AddB in the same cycle.
- Stall  input  1  hazard stall from decode; freezes the PC.
- BranchTaken  input  1  redirect request, single-cycle pulse.
- BranchTarget  input  32  redirect address, valid while BranchTaken=1.
- Exception  input  1  exception entry request, single-cycle pulse.
- FetchValid  output  1  FetchAddr is a valid request.
- FetchReady  input  1  instruction memory accepts the request this cycle.
- FetchAddr  output  32  fetch address; always equals PC.
- PC  output  32  current PC register.
- EPC  output  32  PC captured on exception entry.
- Flush  output  1  one-cycle pulse instructing fetch/decode to discard the in-flight instruction.

Behaviour:
- Reset (Rst=0, asynchronous), all outputs and registers as follows:
  - PC=RESET_PC, EPC=0, state=BOOT.
  - FetchValid=0, Flush=0.
  - AddA=PC, AddB=INC, held combinationally at all times.
- States: BOOT, RUN, HOLD, REDIRECT.
- BOOT:
  - FetchValid=0; PC unchanged.
  - Goes to RUN unconditionally on the first edge after Rst deasserts.
  - First fetch of RESET_PC is therefore issued in cycle 2 after reset release.
- RUN: FetchValid=1. On each edge, events are resolved in priority order:
  1. Exception=1: EPC<=PC, PC<=EXC_VECTOR, Flush<=1, state<=REDIRECT.
  2. BranchTaken=1: PC<=BranchTarget, Flush<=1, state<=REDIRECT.
  3. Stall=1 or FetchReady=0: PC held, state<=HOLD.
  4. Otherwise: PC<=AddSum, so the PC advances by INC every cycle with zero added latency.
- HOLD:
  - FetchValid=1, and FetchAddr stays stable until accepted (valid/ready rule: address and valid must not change while FetchReady=0).
  - Exception and BranchTaken are handled with the same priority as in RUN and override HOLD.
  - When Stall=0 and FetchReady=1: PC<=AddSum, state<=RUN.
- REDIRECT:
  - One bubble cycle: FetchValid=0, Flush=1 is visible for exactly this cycle, and PC is held at the new target.
  - Exception during REDIRECT is honoured: EPC<=PC, i.e. the target address.
  - BranchTaken during REDIRECT is ignored; the upstream pipeline is already flushed.
  - Next state: RUN.
- Flush is registered and is high only while state=REDIRECT.
- Arithmetic:
  - The PC add is performed only by the external adder and wraps modulo 2^32 (32'hFFFF_FFFC+4 -> 32'h0000_0000; no overflow flag).
  - BranchTarget is loaded verbatim; no alignment check is made in this block.
- Simultaneous events:
  - Exception beats BranchTaken beats Stall.
  - Stall and FetchReady=0 together behave like either alone.
- Reset mid-operation: asserting Rst in any state immediately forces the reset values, with no wait for a clock edge.

Test Plan:
- Reset release with Stall=0, FetchReady=1 -> cycle 1 FetchValid=0; cycles 2..5 FetchAddr = 0x0, 0x4, 0x8, 0xC with FetchValid=1; AddB=4 throughout.
- With PC=0x10, hold Stall=1 for 3 cycles -> FetchAddr stays 0x10 with FetchValid=1; 0x14 appears one cycle after Stall drops. Repeat with FetchReady=0 in place of Stall -> identical response.
- With PC=0x20, pulse BranchTaken with BranchTarget=0x400 -> next cycle PC=0x400, Flush=1, FetchValid=0; following cycles fetch 0x400, 0x404.
- With PC=0x30, assert Exception and BranchTaken (target 0x400) in the same cycle -> PC=0x80, EPC=0x30, Flush=1; the branch is dropped.
- With PC forced to 0xFFFF_FFFC via branch -> after the bubble, next fetch address is 0x0000_0000.
- While in HOLD at PC=0x50, drive Rst low between clock edges -> PC=RESET_PC and FetchValid=0 immediately; after release, BOOT then fetch 0x0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage of the fetch path.
// Keeps the current PC, feeds it with the increment to the external adder,
// and chooses the next PC among the adder's sum, a branch target and the
// exception vector. Fetch requests go out over a valid/ready handshake.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] INC        = 32'd4,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic [31:0] AddA,
    output logic [31:0] AddB,
    input  logic [31:0] AddSum,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Exception,
    output logic        FetchValid,
    input  logic        FetchReady,
    output logic [31:0] FetchAddr,
    output logic [31:0] PC,
    output logic [31:0] EPC,
    output logic        Flush
);

    // BOOT: one idle cycle after reset. RUN/HOLD: a fetch is offered.
    // REDIRECT: one bubble cycle after a branch or exception.
    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        HOLD     = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic        flush_q;

    // State register together with PC, EPC and the registered flush pulse.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            epc_q   <= 32'h0000_0000;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            flush_q <= (state_d == REDIRECT);
        end
    end

    // Next-state and next-PC selection; exception beats branch beats stall.
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN, HOLD: begin
                if (Exception) begin
                    epc_d   = pc_q;
                    pc_d    = EXC_VECTOR;
                    state_d = REDIRECT;
                end else if (BranchTaken) begin
                    pc_d    = BranchTarget;
                    state_d = REDIRECT;
                end else if (Stall || !FetchReady) begin
                    // Request not accepted: keep address and valid stable.
                    state_d = HOLD;
                end else begin
                    pc_d    = AddSum;
                    state_d = RUN;
                end
            end
            REDIRECT: begin
                // Upstream is already flushed, so a branch here is dropped;
                // an exception still captures the freshly loaded target.
                state_d = RUN;
                if (Exception) begin
                    epc_d = pc_q;
                    pc_d  = EXC_VECTOR;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Outputs decoded from the registered state and PC.
    always_comb begin
        AddA       = pc_q;
        AddB       = INC;
        PC         = pc_q;
        FetchAddr  = pc_q;
        EPC        = epc_q;
        Flush      = flush_q;
        FetchValid = (state_q == RUN) || (state_q == HOLD);
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios followed by random stimulus, every
// output compared against a cycle-level reference model of the PC stage.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] INC        = 32'd4;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;

    logic        clk;
    logic        rst;
    logic [31:0] add_a, add_b, add_sum;
    logic        stall, branch_taken, exception, fetch_ready;
    logic [31:0] branch_target;
    logic        fetch_valid, flush;
    logic [31:0] fetch_addr, pc, epc;

    int checks = 0;
    int errors = 0;

    // Reference model: PC value, captured EPC, whether the boot cycle has
    // passed, and whether the current cycle is the post-redirect bubble.
    logic [31:0] m_pc, m_epc;
    bit          m_booted, m_bubble;

    pc_sequencer #(
        .RESET_PC  (RESET_PC),
        .INC       (INC),
        .EXC_VECTOR(EXC_VECTOR)
    ) dut (
        .Clk         (clk),
        .Rst         (rst),
        .AddA        (add_a),
        .AddB        (add_b),
        .AddSum      (add_sum),
        .Stall       (stall),
        .BranchTaken (branch_taken),
        .BranchTarget(branch_target),
        .Exception   (exception),
        .FetchValid  (fetch_valid),
        .FetchReady  (fetch_ready),
        .FetchAddr   (fetch_addr),
        .PC          (pc),
        .EPC         (epc),
        .Flush       (flush)
    );

    // External combinational adder.
    assign add_sum = add_a + add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = RESET_PC;
        m_epc    = 32'h0;
        m_booted = 1'b0;
        m_bubble = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        if (!m_booted) begin
            m_booted = 1'b1;
        end else if (m_bubble) begin
            m_bubble = 1'b0;
            if (exception) begin
                m_epc = m_pc;
                m_pc  = EXC_VECTOR;
            end
        end else if (exception) begin
            m_epc    = m_pc;
            m_pc     = EXC_VECTOR;
            m_bubble = 1'b1;
        end else if (branch_taken) begin
            m_pc     = branch_target;
            m_bubble = 1'b1;
        end else if (!stall && fetch_ready) begin
            m_pc = m_pc + INC;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, {31'd0, fetch_valid}, {31'd0, m_booted && !m_bubble});
        check({tag, ".flush"}, {31'd0, flush}, {31'd0, m_bubble});
        check({tag, ".fetch_addr"}, fetch_addr, m_pc);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".epc"}, epc, m_epc);
        check({tag, ".add_a"}, add_a, m_pc);
        check({tag, ".add_b"}, add_b, INC);
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] t,
                         input logic e, input logic r);
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        exception     = e;
        fetch_ready   = r;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        model_reset();

        // Reset state, then BOOT cycle with no fetch.
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all("boot");

        // Sequential fetch 0x0, 0x4, 0x8, 0xC, then 0x10.
        for (int i = 0; i < 5; i++) cycle("seq");
        check("pc_at_0x10", pc, 32'h10);

        // Stall freezes the PC for three cycles.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle("stall");
        check("stall_addr", fetch_addr, 32'h10);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle("stall_release");
        check("after_stall", fetch_addr, 32'h14);

        // FetchReady low behaves like a stall.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("not_ready");
        check("not_ready_addr", fetch_addr, 32'h14);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle("ready_release");
        check("after_ready", fetch_addr, 32'h18);

        // Branch from 0x20 to 0x400.
        cycle("seq");
        cycle("seq");
        check("pc_at_0x20", pc, 32'h20);
        drive(1'b0, 1'b1, 32'h400, 1'b0, 1'b1);
        cycle("branch");
        check("branch_flush", {31'd0, flush}, 32'd1);
        check("branch_pc", pc, 32'h400);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle("branch_bubble_done");
        cycle("branch_next");
        check("branch_next_addr", fetch_addr, 32'h404);

        // Exception and branch together at 0x30: exception wins.
        drive(1'b0, 1'b1, 32'h30, 1'b0, 1'b1);
        cycle("to_0x30");
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle("at_0x30");
        drive(1'b0, 1'b1, 32'h400, 1'b1, 1'b1);
        cycle("exc_and_branch");
        check("exc_pc", pc, 32'h80);
        check("exc_epc", epc, 32'h30);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle("exc_bubble_done");
        cycle("exc_next");

        // PC wraps modulo 2^32.
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        cycle("to_top");
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle("top_fetch");
        cycle("wrap");
        check("wrap_addr", fetch_addr, 32'h0);

        // Asynchronous reset while holding at 0x50.
        drive(1'b0, 1'b1, 32'h50, 1'b0, 1'b1);
        cycle("to_0x50");
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle("at_0x50");
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle("hold_0x50");
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        check("async_reset_pc", pc, RESET_PC);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_all("reboot");
        cycle("reboot_fetch");
        check("reboot_addr", fetch_addr, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, tgt,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
